dual_ram_pass_sequencer: RTL and testbench
==========================================

Name: dual_ram_pass_sequencer

Overview:
Controller that sequences one element-wise pass over the two 512x8 dual-port RAM pair. Port A of both RAMs is read-only; port B of each RAM is write-only. The block issues reads at a shared address, aligns write-back to the RAM read latency, and writes RAM0 <= a0+a1 and RAM1 <= a function of (a0, a1) selected by op. It replaces hand-coded per-experiment FSMs with a start/busy/done handshake driven by a top-level or switch-based launcher.

Parameters:
ADDR_W, 9, RAM address width; depth = 2**ADDR_W
DATA_W, 8, RAM word width
RD_LAT, 1, RAM port-A read latency in cycles from address-presented cycle to q-valid cycle (legal range 1..3)

Ports:
CLOCK_50_I  in  1  system clock
resetn  in  1  asynchronous active-low reset
start_i  in  1  launch request; sampled only in S_IDLE
base_addr_i  in  ADDR_W  first address of the pass
length_i  in  ADDR_W+1  element count; 0 = empty pass; values above 2**ADDR_W clamp to 2**ADDR_W
op_i  in  2  RAM1 function: 00 a0-a1, 01 a1-a0, 10 a0 (copy), 11 RAM1 not written
abort_i  in  1  stop issuing reads; in-flight writes still complete
rd_data0_i  in  DATA_W  RAM0 port-A q
rd_data1_i  in  DATA_W  RAM1 port-A q
rd_addr_o  out  ADDR_W  shared port-A address (registered)
wr_addr_o  out  ADDR_W  shared port-B address (registered)
wr_en_o  out  2  port-B write enables {RAM1, RAM0} (registered)
wr_data0_o  out  DATA_W  RAM0 port-B data (combinational from rd_data)
wr_data1_o  out  DATA_W  RAM1 port-B data (combinational from rd_data)
busy_o  out  1  pass in progress
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: state S_IDLE; rd_addr_o=0, wr_addr_o=0, wr_en_o=00, busy_o=0, done_o=0. Delay line cleared. Reset mid-pass abandons the pass with no further writes.
- States: S_IDLE, S_READ, S_DRAIN, S_DONE.
- S_IDLE: on start_i=1, latch base, clamped length L and op. Load rd_addr_o<=base. If L>0, go to S_READ; if L=0, go to S_DONE.
- Timing: the acceptance edge ends cycle C0. In cycle Ck (k=1..L), rd_addr_o = (base+k-1) mod 2**ADDR_W; address wraps with no error.
- Write alignment: read address and valid bit pass through an RD_LAT-deep delay line. The write for element k occurs in cycle C(k+RD_LAT), with wr_addr_o equal to that element's read address.
  - wr_en_o[0]=1 for every valid element.
  - wr_en_o[1]=valid AND op!=11.
- Write data: wr_data0_o = (rd_data0_i+rd_data1_i) mod 2**DATA_W. wr_data1_o per op, with subtraction two's-complement mod 2**DATA_W. No saturation.
- S_READ: after the read issued in CL, go to S_DRAIN. rd_addr_o holds its last value.
- S_DRAIN: remains until the delay line is empty (RD_LAT cycles), then go to S_DONE.
- S_DONE: done_o=1 for exactly one cycle, then S_IDLE.
- busy_o=1 in S_READ and S_DRAIN only.
  - Full pass: busy in C1..C(L+RD_LAT); done_o in C(L+RD_LAT+1).
  - Empty pass: busy never rises; done_o in C1.
- start_i is ignored while not in S_IDLE. A new start is accepted in the cycle after done_o at the earliest.
- abort_i in S_READ: the read at the current rd_addr_o is still counted as issued. No further reads; go to S_DRAIN. Issued elements are written normally, then done_o pulses. abort_i is ignored in other states.
- Simultaneous abort_i and the last read in S_READ are indistinguishable from normal completion.
- wr_en_o is never asserted outside a valid delay-line slot; no spurious write in C0 or after drain.

Decomposition:
- Package dual_ram_seq_pkg:
  - state enum
  - op codes OP_DIFF, OP_RDIFF, OP_COPY, OP_NONE
  - default ADDR_W/DATA_W constants
- Sub-module ram_seq_delay_line: RAM_LAT-deep shift register of {valid, addr}, with async reset clearing all valid bits. The sequencer instantiates it once with RD_LAT.

Test Plan:
- RAM0[i]=i, RAM1[i]=2i mod 256, base=0, L=512, op=00, RD_LAT=1 -> RAM0[i]=3i mod 256, RAM1[i]=(-i) mod 256; busy_o high 513 cycles; done_o in C514.
- base=510, L=4, op=10 -> writes to 510,511,0,1 only (wrap); RAM1 copies RAM0's old values; all other addresses unchanged.
- L=0 start -> done_o in C1; wr_en_o stays 00; busy_o stays 0.
- L=100, abort_i pulsed in C10 -> exactly 10 elements written (base..base+9), RAM1 included; done_o in C12.
- RAM0[5]=0xF0, RAM1[5]=0x20, op=01 -> RAM0[5]=0x10, RAM1[5]=0x30; repeat with op=11 -> RAM1[5] unchanged.
- resetn low in C50 of an L=200 pass -> all outputs at reset values immediately; no writes after release; a new start runs a clean pass. Repeat directed runs with RD_LAT=2.

Source files
------------

// File: rtl/dual_ram_pass_sequencer_pkg.sv
// Shared types and defaults for the dual-RAM pass sequencer.
package dual_ram_seq_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_DIFF  = 2'b00,
    OP_RDIFF = 2'b01,
    OP_COPY  = 2'b10,
    OP_NONE  = 2'b11
  } op_t;

endpackage

// File: rtl/dual_ram_pass_sequencer_if.sv
// Launcher/RAM-facing bundle of the pass sequencer.
interface dual_ram_pass_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [ADDR_W:0]   length_i;
  logic [1:0]        op_i;
  logic              abort_i;
  logic [DATA_W-1:0] rd_data0_i;
  logic [DATA_W-1:0] rd_data1_i;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [1:0]        wr_en_o;
  logic [DATA_W-1:0] wr_data0_o;
  logic [DATA_W-1:0] wr_data1_o;
  logic              busy_o;
  logic              done_o;

  modport slave (
    input  start_i, base_addr_i, length_i, op_i, abort_i, rd_data0_i, rd_data1_i,
    output rd_addr_o, wr_addr_o, wr_en_o, wr_data0_o, wr_data1_o, busy_o, done_o
  );

  modport master (
    output start_i, base_addr_i, length_i, op_i, abort_i, rd_data0_i, rd_data1_i,
    input  rd_addr_o, wr_addr_o, wr_en_o, wr_data0_o, wr_data1_o, busy_o, done_o
  );
endinterface

// File: rtl/dual_ram_pass_sequencer_delay_line.sv
// Shift register carrying {valid, addr} of each issued read until its data returns.
module ram_seq_delay_line #(
  parameter int RAM_LAT = 1,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vld,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_addr
);

  logic [RAM_LAT:1]             r_vld;
  logic [RAM_LAT:1][ADDR_W-1:0] r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_addr <= '0;
    end else begin
      for (int s = RAM_LAT; s > 1; s--) begin
        r_vld[s]  <= r_vld[s-1];
        r_addr[s] <= r_addr[s-1];
      end
      r_vld[1]  <= i_vld;
      r_addr[1] <= i_addr;
    end
  end

  assign o_vld  = r_vld[RAM_LAT];
  assign o_addr = r_addr[RAM_LAT];

endmodule

// File: rtl/dual_ram_pass_sequencer.sv
// One element-wise pass over the RAM pair: shared-address reads, latency-aligned
// write-back of a0+a1 to RAM0 and an op-selected function to RAM1.
module dual_ram_pass_sequencer
  import dual_ram_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input logic                       CLOCK_50_I,
  input logic                       resetn,
  dual_ram_pass_sequencer_if.slave  bus
);

  localparam int unsigned   DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] L_MAX  = DEPTH[ADDR_W:0];
  localparam logic [1:0]    DRAIN_LD = 2'(RD_LAT - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [ADDR_W:0]   r_left, w_left_nxt;
  op_t               r_op, w_op_nxt;
  logic [1:0]        r_drain, w_drain_nxt;
  logic [ADDR_W:0]   w_len;
  logic              w_wr_vld;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_d1;

  assign w_len = (bus.length_i > L_MAX) ? L_MAX : bus.length_i;

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_left    <= '0;
      r_op      <= OP_DIFF;
      r_drain   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_left    <= w_left_nxt;
      r_op      <= w_op_nxt;
      r_drain   <= w_drain_nxt;
    end
  end

  // r_left counts reads still to issue, including the one at r_rd_addr.
  always_comb begin
    w_state_nxt   = r_state;
    w_rd_addr_nxt = r_rd_addr;
    w_left_nxt    = r_left;
    w_op_nxt      = r_op;
    w_drain_nxt   = r_drain;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_rd_addr_nxt = bus.base_addr_i;
          w_left_nxt    = w_len;
          w_op_nxt      = op_t'(bus.op_i);
          w_state_nxt   = (w_len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (r_left == (ADDR_W+1)'(1) || bus.abort_i) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = DRAIN_LD;
        end else begin
          w_rd_addr_nxt = r_rd_addr + 1'b1;
          w_left_nxt    = r_left - 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain == '0) w_state_nxt = S_DONE;
        else               w_drain_nxt = r_drain - 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  ram_seq_delay_line #(
    .RAM_LAT (RD_LAT),
    .ADDR_W  (ADDR_W)
  ) u_dly (
    .clk    (CLOCK_50_I),
    .rst_n  (resetn),
    .i_vld  (r_state == S_READ),
    .i_addr (r_rd_addr),
    .o_vld  (w_wr_vld),
    .o_addr (w_wr_addr)
  );

  always_comb begin
    w_d1 = bus.rd_data0_i;
    case (r_op)
      OP_DIFF:  w_d1 = bus.rd_data0_i - bus.rd_data1_i;
      OP_RDIFF: w_d1 = bus.rd_data1_i - bus.rd_data0_i;
      default:  w_d1 = bus.rd_data0_i;
    endcase
  end

  assign bus.rd_addr_o  = r_rd_addr;
  assign bus.wr_addr_o  = w_wr_addr;
  assign bus.wr_en_o    = {w_wr_vld && (r_op != OP_NONE), w_wr_vld};
  assign bus.wr_data0_o = bus.rd_data0_i + bus.rd_data1_i;
  assign bus.wr_data1_o = w_d1;
  assign bus.busy_o     = (r_state == S_READ) || (r_state == S_DRAIN);
  assign bus.done_o     = (r_state == S_DONE);

endmodule

// File: tb/tb_dual_ram_pass_sequencer.sv
// Two sequencers (RD_LAT=1 and 2) share stimulus; each has its own RAM model and
// is checked against whole-array expectations computed from the pass rules.
module tb_dual_ram_pass_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start, abort;
  logic [8:0] base;
  logic [9:0] len;
  logic [1:0] op;

  logic [7:0] q0 [2];
  logic [7:0] q1 [2];
  logic [7:0] qp0 [2][3];
  logic [7:0] qp1 [2][3];
  logic [8:0] rd_addr_w [2];
  logic [8:0] wr_addr_w [2];
  logic [1:0] wr_en_w [2];
  logic [7:0] wd0_w [2];
  logic [7:0] wd1_w [2];
  logic       busy_w [2];
  logic       done_w [2];

  logic [7:0] mem0 [2][512];
  logic [7:0] mem1 [2][512];
  logic [7:0] exp0 [2][512];
  logic [7:0] exp1 [2][512];
  int wr0_cnt [2];
  int wr1_cnt [2];
  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dual_ram_pass_sequencer_if #(.ADDR_W(9), .DATA_W(8)) bif ();
    assign bif.start_i     = start;
    assign bif.base_addr_i = base;
    assign bif.length_i    = len;
    assign bif.op_i        = op;
    assign bif.abort_i     = abort;
    assign bif.rd_data0_i  = q0[g];
    assign bif.rd_data1_i  = q1[g];
    assign rd_addr_w[g] = bif.rd_addr_o;
    assign wr_addr_w[g] = bif.wr_addr_o;
    assign wr_en_w[g]   = bif.wr_en_o;
    assign wd0_w[g]     = bif.wr_data0_o;
    assign wd1_w[g]     = bif.wr_data1_o;
    assign busy_w[g]    = bif.busy_o;
    assign done_w[g]    = bif.done_o;
    dual_ram_pass_sequencer #(.ADDR_W(9), .DATA_W(8), .RD_LAT(g + 1)) u_dut (
      .CLOCK_50_I (clk),
      .resetn     (rst_n),
      .bus        (bif.slave)
    );
  end

  // RAM service at the rising edge (pre-update DUT values), then return at the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      if (wr_en_w[g][0]) begin mem0[g][wr_addr_w[g]] = wd0_w[g]; wr0_cnt[g]++; end
      if (wr_en_w[g][1]) begin mem1[g][wr_addr_w[g]] = wd1_w[g]; wr1_cnt[g]++; end
    end
    for (int g = 0; g < 2; g++) begin
      for (int s = 2; s > 0; s--) begin
        qp0[g][s] = qp0[g][s-1];
        qp1[g][s] = qp1[g][s-1];
      end
      qp0[g][0] = mem0[g][rd_addr_w[g]];
      qp1[g][0] = mem1[g][rd_addr_w[g]];
      q0[g] = qp0[g][g];
      q1[g] = qp1[g][g];
    end
    @(negedge clk);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 512; a++) begin
      logic [7:0] v0, v1;
      v0 = 8'($urandom);
      v1 = 8'($urandom);
      for (int g = 0; g < 2; g++) begin mem0[g][a] = v0; mem1[g][a] = v1; end
    end
  endtask

  // Expected image: n elements from base, each address touched once.
  task automatic model(input int g, input logic [8:0] b, input int n, input logic [1:0] o);
    for (int a = 0; a < 512; a++) begin exp0[g][a] = mem0[g][a]; exp1[g][a] = mem1[g][a]; end
    for (int k = 0; k < n; k++) begin
      int a;
      logic [7:0] s0, s1;
      a  = (int'(b) + k) % 512;
      s0 = mem0[g][a];
      s1 = mem1[g][a];
      exp0[g][a] = s0 + s1;
      case (o)
        2'b00: exp1[g][a] = s0 - s1;
        2'b01: exp1[g][a] = s1 - s0;
        2'b10: exp1[g][a] = s0;
        default: ;
      endcase
    end
  endtask

  task automatic check_mem(input string nm);
    for (int g = 0; g < 2; g++) begin
      int bad0, bad1, f0, f1;
      bad0 = 0; bad1 = 0; f0 = 0; f1 = 0;
      for (int a = 0; a < 512; a++) begin
        if (mem0[g][a] !== exp0[g][a]) begin if (bad0 == 0) f0 = a; bad0++; end
        if (mem1[g][a] !== exp1[g][a]) begin if (bad1 == 0) f1 = a; bad1++; end
      end
      n_cmp++;
      if (bad0 != 0) begin
        n_err++;
        $display("FAIL %s ram0 lat%0d: %0d bad addrs, first @%0d got %h want %h",
                 nm, g + 1, bad0, f0, mem0[g][f0], exp0[g][f0]);
      end
      n_cmp++;
      if (bad1 != 0) begin
        n_err++;
        $display("FAIL %s ram1 lat%0d: %0d bad addrs, first @%0d got %h want %h",
                 nm, g + 1, bad1, f1, mem1[g][f1], exp1[g][f1]);
      end
    end
  endtask

  task automatic run_pass(input logic [8:0] b, input logic [9:0] l, input logic [1:0] o,
                          input int ab, input bit hold, input string nm);
    int lc, n;
    int bcnt [2];
    int dcyc [2];
    lc = (l > 10'd512) ? 512 : int'(l);
    n  = (ab > 0 && ab < lc) ? ab : lc;
    for (int g = 0; g < 2; g++) begin
      model(g, b, n, o);
      wr0_cnt[g] = 0; wr1_cnt[g] = 0; bcnt[g] = 0; dcyc[g] = 0;
    end
    start = 1'b1; base = b; len = l; op = o; abort = 1'b0;
    tick();
    for (int c = 1; c <= 1200; c++) begin
      start = hold && (n > 0) && (c <= n + 1);
      abort = (c == ab);
      for (int g = 0; g < 2; g++) begin
        if (busy_w[g]) bcnt[g]++;
        if (done_w[g] && dcyc[g] == 0) dcyc[g] = c;
      end
      if (dcyc[0] != 0 && dcyc[1] != 0) break;
      tick();
    end
    start = 1'b0; abort = 1'b0;
    tick();
    for (int g = 0; g < 2; g++) begin
      int ed, eb, e1;
      ed = (n > 0) ? n + g + 2 : 1;
      eb = (n > 0) ? n + g + 1 : 0;
      e1 = (o == 2'b11) ? 0 : n;
      n_cmp++;
      if (dcyc[g] !== ed) begin
        n_err++;
        $display("FAIL %s done_cycle lat%0d: got C%0d want C%0d", nm, g + 1, dcyc[g], ed);
      end
      n_cmp++;
      if (bcnt[g] !== eb) begin
        n_err++;
        $display("FAIL %s busy_cycles lat%0d: got %0d want %0d", nm, g + 1, bcnt[g], eb);
      end
      n_cmp++;
      if (wr0_cnt[g] !== n || wr1_cnt[g] !== e1) begin
        n_err++;
        $display("FAIL %s write_count lat%0d: got %0d/%0d want %0d/%0d",
                 nm, g + 1, wr0_cnt[g], wr1_cnt[g], n, e1);
      end
    end
    check_mem(nm);
  endtask

  task automatic check_idle_outputs(input string nm);
    for (int g = 0; g < 2; g++) begin
      logic [21:0] v;
      v = {rd_addr_w[g], wr_addr_w[g], wr_en_w[g], busy_w[g], done_w[g]};
      n_cmp++;
      if (v !== 22'd0) begin
        n_err++;
        $display("FAIL %s outputs lat%0d: got {rd,wr,en,busy,done}=%h want 0", nm, g + 1, v);
      end
    end
  endtask

  task automatic test_reset();
    start = 0; abort = 0; base = 0; len = 0; op = 0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_asserted");
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    check_idle_outputs("reset_released");
  endtask

  task automatic test_full_pass();
    for (int a = 0; a < 512; a++)
      for (int g = 0; g < 2; g++) begin mem0[g][a] = 8'(a); mem1[g][a] = 8'(2 * a); end
    run_pass(9'd0, 10'd512, 2'b00, 0, 1'b0, "full_pass");
    for (int g = 0; g < 2; g++) begin
      n_cmp++;
      if (mem0[g][100] !== 8'h2C || mem1[g][100] !== 8'd156) begin
        n_err++;
        $display("FAIL full_pass_elem100 lat%0d: got %h/%h want 2c/9c", g + 1, mem0[g][100], mem1[g][100]);
      end
    end
  endtask

  task automatic test_wrap();
    fill_random();
    run_pass(9'd510, 10'd4, 2'b10, 0, 1'b0, "wrap_copy");
  endtask

  task automatic test_empty();
    run_pass(9'($urandom), 10'd0, 2'b00, 0, 1'b0, "empty_pass");
  endtask

  task automatic test_abort();
    fill_random();
    run_pass(9'd300, 10'd100, 2'b00, 10, 1'b0, "abort_c10");
  endtask

  task automatic test_ops();
    for (int g = 0; g < 2; g++) begin mem0[g][5] = 8'hF0; mem1[g][5] = 8'h20; end
    run_pass(9'd5, 10'd1, 2'b01, 0, 1'b0, "op_rdiff");
    for (int g = 0; g < 2; g++) begin
      n_cmp++;
      if (mem0[g][5] !== 8'h10 || mem1[g][5] !== 8'h30) begin
        n_err++;
        $display("FAIL op_rdiff_direct lat%0d: got %h/%h want 10/30", g + 1, mem0[g][5], mem1[g][5]);
      end
    end
    run_pass(9'd5, 10'd1, 2'b11, 0, 1'b0, "op_none");
    for (int g = 0; g < 2; g++) begin
      n_cmp++;
      if (mem0[g][5] !== 8'h40 || mem1[g][5] !== 8'h30) begin
        n_err++;
        $display("FAIL op_none_direct lat%0d: got %h/%h want 40/30", g + 1, mem0[g][5], mem1[g][5]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] b;
    fill_random();
    b = 9'($urandom);
    // Writes completed before the reset in C50 are those landing in C2..C49.
    for (int g = 0; g < 2; g++) model(g, b, 49 - (g + 1), 2'b00);
    start = 1'b1; base = b; len = 10'd200; op = 2'b00; abort = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c < 50; c++) tick();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_pass");
    for (int g = 0; g < 2; g++) begin wr0_cnt[g] = 0; wr1_cnt[g] = 0; end
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    for (int g = 0; g < 2; g++) begin
      n_cmp++;
      if (wr0_cnt[g] + wr1_cnt[g] !== 0 || busy_w[g] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_quiet lat%0d: got writes=%0d busy=%b want 0/0",
                 g + 1, wr0_cnt[g] + wr1_cnt[g], busy_w[g]);
      end
    end
    check_mem("reset_mid_mem");
    run_pass(9'($urandom), 10'd37, 2'b01, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [9:0] l;
      int ab;
      fill_random();
      l  = (i == 0) ? 10'd700 : 10'($urandom_range(0, 600));
      ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : 0;
      run_pass(9'($urandom), l, 2'($urandom), ab, 1'($urandom), $sformatf("random%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_pass(9'd20, 10'd8, 2'b00, 0, 1'b1, "b2b_first");
    run_pass(9'd24, 10'd8, 2'b01, 0, 1'b1, "b2b_second");
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      q0[g] = 0; q1[g] = 0; wr0_cnt[g] = 0; wr1_cnt[g] = 0;
      for (int s = 0; s < 3; s++) begin qp0[g][s] = 0; qp1[g][s] = 0; end
      for (int a = 0; a < 512; a++) begin mem0[g][a] = 0; mem1[g][a] = 0; end
    end
    test_reset();
    test_full_pass();
    test_wrap();
    test_empty();
    test_abort();
    test_ops();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog expired");
  end

endmodule
